// File: rtl/id_ex_operand_stage_pkg.sv
// Shared definitions for the ID->EX operand stage.
// Holds the zero-register index, default datapath widths, the operand
// bypass-select encoding, and a small helper that compares a register index
// against a producer destination while never matching register 0.
package id_ex_operand_stage_pkg;

  localparam logic [4:0] REG_ZERO       = 5'd0;
  localparam int         WIDTH_DEFAULT  = 32;
  localparam int         CTRL_W_DEFAULT = 8;
  localparam int         CNT_W_DEFAULT  = 16;

  // Which source feeds an operand into the ID/EX register
  typedef enum logic [1:0] {
    BYP_RF  = 2'd0,
    BYP_EX  = 2'd1,
    BYP_MEM = 2'd2
  } bypass_sel_e;

  // Register 0 is hard-wired to zero, so a producer targeting it must never
  // be treated as a match for forwarding or hazard purposes.
  function automatic logic addrMatch(input logic [4:0] reader, input logic [4:0] producer);
    return (reader == producer) && (reader != REG_ZERO);
  endfunction

endpackage

// File: rtl/id_ex_operand_stage_operand_bypass_mux.sv
// Per-operand bypass selector for the ID->EX stage.
// Chooses between the register-file value, the EX-stage ALU result and the
// MEM-stage write value, and flags when the operand depends on a load that
// is still in EX (the load-use case the top level must stall on).
// Ports:
//   i_addr          operand register index
//   i_use           instruction actually reads this operand
//   i_rf_data       register file read data
//   i_ex_valid/i_ex_reg_we/i_ex_mem_read/i_ex_dst/i_ex_alu_result
//                   state of the instruction currently in EX
//   i_mem_reg_we/i_mem_dst/i_mem_result
//                   MEM-stage writeback information
//   o_value         forwarded operand value
//   o_select        which source was chosen
//   o_load_hit      operand needs the result of a load still in EX
module operand_bypass_mux
  import id_ex_operand_stage_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic [4:0]       i_addr,
  input  logic             i_use,
  input  logic [WIDTH-1:0] i_rf_data,
  input  logic             i_ex_valid,
  input  logic             i_ex_reg_we,
  input  logic             i_ex_mem_read,
  input  logic [4:0]       i_ex_dst,
  input  logic [WIDTH-1:0] i_ex_alu_result,
  input  logic             i_mem_reg_we,
  input  logic [4:0]       i_mem_dst,
  input  logic [WIDTH-1:0] i_mem_result,
  output logic [WIDTH-1:0] o_value,
  output bypass_sel_e      o_select,
  output logic             o_load_hit
);

  // A load in EX has no data yet, so it is excluded from EX forwarding; the
  // stall logic holds the consumer until the load reaches MEM.
  always_comb begin
    o_select = BYP_RF;
    if (i_ex_valid && i_ex_reg_we && !i_ex_mem_read && addrMatch(i_addr, i_ex_dst)) begin
      o_select = BYP_EX;
    end else if (i_mem_reg_we && addrMatch(i_addr, i_mem_dst)) begin
      o_select = BYP_MEM;
    end
  end

  always_comb begin
    o_value = i_rf_data;
    case (o_select)
      BYP_EX:  o_value = i_ex_alu_result;
      BYP_MEM: o_value = i_mem_result;
      default: o_value = i_rf_data;
    endcase
  end

  assign o_load_hit = i_use && i_ex_valid && i_ex_mem_read && addrMatch(i_addr, i_ex_dst);

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID->EX pipeline stage sitting directly after the register file.
// Forwards in-flight EX/MEM results into the Rs/Rt operands, detects
// load-use hazards (one stall cycle plus a bubble), registers operands and
// control for EX, and counts stall cycles with a saturating counter.
// The register file writes on the falling edge, so WB results are already
// visible in the read data and need no forwarding path here.
// Ports:
//   i_clk, i_rst            clock and synchronous active-high reset
//   i_id_*                  decoded instruction currently in ID
//   i_rf_rs_data/rt_data    register file read data for Rs/Rt
//   i_flush                 redirect: kill the ID instruction
//   i_ex_alu_result         combinational result of the instruction in EX
//   i_mem_dst/reg_we/result MEM-stage writeback information
//   o_stall                 holds PC and IF/ID upstream
//   o_ex_*                  registered instruction for EX
//   o_stall_cnt             saturating count of stall cycles
module id_ex_operand_stage
  import id_ex_operand_stage_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEFAULT,
  parameter int CTRL_W = CTRL_W_DEFAULT,
  parameter int CNT_W  = CNT_W_DEFAULT
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_id_valid,
  input  logic [4:0]        i_id_rs_addr,
  input  logic [4:0]        i_id_rt_addr,
  input  logic              i_id_uses_rs,
  input  logic              i_id_uses_rt,
  input  logic [WIDTH-1:0]  i_rf_rs_data,
  input  logic [WIDTH-1:0]  i_rf_rt_data,
  input  logic [WIDTH-1:0]  i_id_imm,
  input  logic [4:0]        i_id_dst,
  input  logic              i_id_reg_we,
  input  logic              i_id_mem_read,
  input  logic [CTRL_W-1:0] i_id_ctrl,
  input  logic              i_flush,
  input  logic [WIDTH-1:0]  i_ex_alu_result,
  input  logic [4:0]        i_mem_dst,
  input  logic              i_mem_reg_we,
  input  logic [WIDTH-1:0]  i_mem_result,
  output logic              o_stall,
  output logic              o_ex_valid,
  output logic [WIDTH-1:0]  o_ex_rs_val,
  output logic [WIDTH-1:0]  o_ex_rt_val,
  output logic [WIDTH-1:0]  o_ex_imm,
  output logic [4:0]        o_ex_dst,
  output logic              o_ex_reg_we,
  output logic              o_ex_mem_read,
  output logic [CTRL_W-1:0] o_ex_ctrl,
  output logic [CNT_W-1:0]  o_stall_cnt
);

  logic              r_ex_valid;
  logic [WIDTH-1:0]  r_ex_rs_val;
  logic [WIDTH-1:0]  r_ex_rt_val;
  logic [WIDTH-1:0]  r_ex_imm;
  logic [4:0]        r_ex_dst;
  logic              r_ex_reg_we;
  logic              r_ex_mem_read;
  logic [CTRL_W-1:0] r_ex_ctrl;
  logic [CNT_W-1:0]  r_stall_cnt;

  logic [WIDTH-1:0]  w_rs_val;
  logic [WIDTH-1:0]  w_rt_val;
  bypass_sel_e       w_rs_sel;
  bypass_sel_e       w_rt_sel;
  logic              w_rs_load_hit;
  logic              w_rt_load_hit;
  logic              w_load_use;
  logic              w_stall;
  logic              w_bubble;
  logic [3:0]        w_unused_sel;

  operand_bypass_mux #(.WIDTH(WIDTH)) u_rs_bypass (
    .i_addr          (i_id_rs_addr),
    .i_use           (i_id_uses_rs),
    .i_rf_data       (i_rf_rs_data),
    .i_ex_valid      (r_ex_valid),
    .i_ex_reg_we     (r_ex_reg_we),
    .i_ex_mem_read   (r_ex_mem_read),
    .i_ex_dst        (r_ex_dst),
    .i_ex_alu_result (i_ex_alu_result),
    .i_mem_reg_we    (i_mem_reg_we),
    .i_mem_dst       (i_mem_dst),
    .i_mem_result    (i_mem_result),
    .o_value         (w_rs_val),
    .o_select        (w_rs_sel),
    .o_load_hit      (w_rs_load_hit)
  );

  operand_bypass_mux #(.WIDTH(WIDTH)) u_rt_bypass (
    .i_addr          (i_id_rt_addr),
    .i_use           (i_id_uses_rt),
    .i_rf_data       (i_rf_rt_data),
    .i_ex_valid      (r_ex_valid),
    .i_ex_reg_we     (r_ex_reg_we),
    .i_ex_mem_read   (r_ex_mem_read),
    .i_ex_dst        (r_ex_dst),
    .i_ex_alu_result (i_ex_alu_result),
    .i_mem_reg_we    (i_mem_reg_we),
    .i_mem_dst       (i_mem_dst),
    .i_mem_result    (i_mem_result),
    .o_value         (w_rt_val),
    .o_select        (w_rt_sel),
    .o_load_hit      (w_rt_load_hit)
  );

  // The select codes are kept for waveform debug only; nothing downstream
  // consumes them.
  assign w_unused_sel = {w_rs_sel, w_rt_sel};

  // A flush kills the dependent instruction anyway, so it suppresses the
  // stall; reset also forces the stall low so upstream is never frozen.
  assign w_load_use = i_id_valid && (w_rs_load_hit || w_rt_load_hit);
  assign w_stall    = w_load_use && !i_flush && !i_rst;
  assign w_bubble   = i_flush || w_stall;

  // Pipeline register. Bubbles clear only the fields that can cause side
  // effects; operand/immediate/destination are left as they were since EX
  // ignores them when valid is low.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ex_valid    <= 1'b0;
      r_ex_rs_val   <= '0;
      r_ex_rt_val   <= '0;
      r_ex_imm      <= '0;
      r_ex_dst      <= REG_ZERO;
      r_ex_reg_we   <= 1'b0;
      r_ex_mem_read <= 1'b0;
      r_ex_ctrl     <= '0;
    end else if (w_bubble) begin
      r_ex_valid    <= 1'b0;
      r_ex_reg_we   <= 1'b0;
      r_ex_mem_read <= 1'b0;
      r_ex_ctrl     <= '0;
    end else begin
      r_ex_valid    <= i_id_valid;
      r_ex_rs_val   <= w_rs_val;
      r_ex_rt_val   <= w_rt_val;
      r_ex_imm      <= i_id_imm;
      r_ex_dst      <= i_id_dst;
      r_ex_reg_we   <= i_id_valid && i_id_reg_we;
      r_ex_mem_read <= i_id_valid && i_id_mem_read;
      r_ex_ctrl     <= i_id_valid ? i_id_ctrl : '0;
    end
  end

  // Stall performance counter, saturating at all-ones.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign o_stall       = w_stall;
  assign o_ex_valid    = r_ex_valid;
  assign o_ex_rs_val   = r_ex_rs_val;
  assign o_ex_rt_val   = r_ex_rt_val;
  assign o_ex_imm      = r_ex_imm;
  assign o_ex_dst      = r_ex_dst;
  assign o_ex_reg_we   = r_ex_reg_we;
  assign o_ex_mem_read = r_ex_mem_read;
  assign o_ex_ctrl     = r_ex_ctrl;
  assign o_stall_cnt   = r_stall_cnt;

endmodule
